gpp_prog_loader: RTL and testbench

- Writer side of the instruction-memory interface that the calculator core reads during IF.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes each word into instruction memory through a single write port.
- Holds the core in reset until a complete, valid image has been loaded.

---
 rtl/gpp_prog_loader.sv | 130 +++++++++++++
 tb/tb_gpp_prog_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpp_prog_loader.sv
// Loads a framed big-endian 16-bit image into instruction memory and holds the core in reset until it is complete.
// Build with LOADER_CSUM_EN to require and check the trailing XOR checksum byte.
module gpp_prog_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [15:0]       im_data,
   output logic              core_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_LEN_HI  = 4'd1;
   localparam logic [3:0] S_LEN_LO  = 4'd2;
   localparam logic [3:0] S_DATA_HI = 4'd3;
   localparam logic [3:0] S_DATA_LO = 4'd4;
   localparam logic [3:0] S_WRITE   = 4'd5;
   localparam logic [3:0] S_DONE    = 4'd6;
   localparam logic [3:0] S_ERR     = 4'd7;
`ifdef LOADER_CSUM_EN
   localparam logic [3:0] S_CSUM    = 4'd8;
   localparam logic [3:0] S_TAIL    = S_CSUM;
`else
   localparam logic [3:0] S_TAIL    = S_DONE;
`endif
   localparam logic [16:0] DEPTH_L  = 17'(DEPTH);

   logic [3:0]  state;
   logic [15:0] len;
   logic [15:0] len_next;
   logic        take;
   logic        arm;
   logic        last_word;

   assign take      = in_valid & in_ready;
   assign arm       = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
   assign len_next  = {len[15:8], in_data};
   assign last_word = (16'(words_loaded) + 16'd1) == len;

   always_comb begin
      in_ready = (state == S_LEN_HI) | (state == S_LEN_LO) |
                 (state == S_DATA_HI) | (state == S_DATA_LO);
`ifdef LOADER_CSUM_EN
      if (state == S_CSUM) in_ready = 1'b1;
`endif
   end

   assign im_we     = (state == S_WRITE);
   assign done      = (state == S_DONE);
   assign err       = (state == S_ERR);
   assign busy      = (state != S_IDLE) & (state != S_DONE) & (state != S_ERR);
   assign core_hold = (state != S_DONE);

`ifdef LOADER_CSUM_EN
   logic [7:0] csum;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       csum <= '0;
      else if (arm)  csum <= '0;
      else if (take) csum <= csum ^ in_data;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         len          <= '0;
         im_addr      <= '0;
         im_data      <= '0;
         words_loaded <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state        <= S_LEN_HI;
                  im_addr      <= '0;
                  words_loaded <= '0;
               end
            end
            S_LEN_HI: begin
               if (take) begin
                  len[15:8] <= in_data;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               // Oversize is rejected here, before any write can wrap im_addr.
               if (take) begin
                  len[7:0] <= in_data;
                  if ({1'b0, len_next} > DEPTH_L) state <= S_ERR;
                  else if (len_next == 16'd0)      state <= S_TAIL;
                  else                             state <= S_DATA_HI;
               end
            end
            S_DATA_HI: begin
               if (take) begin
                  im_data[15:8] <= in_data;
                  state         <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (take) begin
                  im_data[7:0] <= in_data;
                  state        <= S_WRITE;
               end
            end
            S_WRITE: begin
               im_addr      <= im_addr + ADDR_W'(1);
               words_loaded <= words_loaded + (ADDR_W+1)'(1);
               state        <= last_word ? S_TAIL : S_DATA_HI;
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: begin
               if (take) state <= (in_data == csum) ? S_DONE : S_ERR;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gpp_prog_loader.sv
// Directed bench for gpp_prog_loader; adapts to the LOADER_CSUM_EN build.
module tb_gpp_prog_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        im_we;
   logic [9:0]  im_addr;
   logic [15:0] im_data;
   logic        core_hold;
   logic        busy;
   logic        done;
   logic        err;
   logic [10:0] words_loaded;

   int total = 0;
   int bad = 0;

   logic [7:0]  frm [0:15];
   int          frm_len;
   logic [15:0] exp_w [0:2] = '{16'h1234, 16'hABCD, 16'h00FF};

   logic [9:0]  wr_addr [0:63];
   logic [15:0] wr_data [0:63];
   int          nwr = 0;
   int          viol = 0;

   gpp_prog_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
      .core_hold(core_hold), .busy(busy), .done(done), .err(err),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Write capture; in_ready during a write strobe is recorded as a violation.
   always @(negedge clk) begin
      if (im_we) begin
         if (nwr < 64) begin
            wr_addr[nwr] = im_addr;
            wr_data[nwr] = im_data;
         end
         nwr = nwr + 1;
         if (in_ready) viol = viol + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1);
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_range(input int lo, input int hi, input bit stall);
      int i = lo;
      int cyc = 0;
      bit acc;
      while (i < hi && cyc < 500) begin
         in_valid = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
         in_data  = frm[i];
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) i++;
         cyc++;
      end
      in_valid = 1'b0;
      total++;
      if (i != hi) begin
         bad++;
         $display("FAIL send_timeout: bytes_accepted=%0d required=%0d", i, hi);
      end
   endtask

   task automatic build_nominal;
      frm[0] = 8'h00; frm[1] = 8'h03;
      frm[2] = 8'h12; frm[3] = 8'h34;
      frm[4] = 8'hAB; frm[5] = 8'hCD;
      frm[6] = 8'h00; frm[7] = 8'hFF;
      frm_len = 8;
`ifdef LOADER_CSUM_EN
      frm[8] = 8'hBC;
      frm_len = 9;
`endif
   endtask

   task automatic test_reset;
      #2;
      total++;
      if ({core_hold, in_ready, im_we, busy, done, err} !== 6'b100000) begin
         bad++;
         $display("FAIL reset_flags: got=%b want=100000", {core_hold, in_ready, im_we, busy, done, err});
      end
      total++;
      if (im_addr !== 10'd0 || im_data !== 16'h0 || words_loaded !== 11'd0) begin
         bad++;
         $display("FAIL reset_regs: addr=%0d data=%h words=%0d want 0", im_addr, im_data, words_loaded);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_cycles(1);
      total++;
      if (in_ready !== 1'b0 || core_hold !== 1'b1) begin
         bad++;
         $display("FAIL idle: in_ready=%b core_hold=%b want 0/1", in_ready, core_hold);
      end
   endtask

   task automatic test_nominal;
      int base = nwr;
      build_nominal;
      pulse_start;
      total++;
      if ({busy, core_hold, in_ready} !== 3'b111) begin
         bad++;
         $display("FAIL armed: busy/hold/rdy=%b want 111", {busy, core_hold, in_ready});
      end
      send_range(0, frm_len, 1'b0);
`ifdef LOADER_CSUM_EN
      total++;
      if (done !== 1'b1 || core_hold !== 1'b0) begin
         bad++;
         $display("FAIL hold_release: done=%b core_hold=%b want 1/0", done, core_hold);
      end
`else
      total++;
      if (im_we !== 1'b1 || core_hold !== 1'b1) begin
         bad++;
         $display("FAIL last_write: im_we=%b core_hold=%b want 1/1", im_we, core_hold);
      end
      wait_cycles(1);
      total++;
      if (done !== 1'b1 || core_hold !== 1'b0) begin
         bad++;
         $display("FAIL hold_release: done=%b core_hold=%b want 1/0", done, core_hold);
      end
`endif
      wait_cycles(2);
      total++;
      if (nwr - base !== 3) begin
         bad++;
         $display("FAIL nominal_count: writes=%0d want 3", nwr - base);
      end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (wr_addr[base+k] !== 10'(k) || wr_data[base+k] !== exp_w[k]) begin
            bad++;
            $display("FAIL nominal_word%0d: got %h@%0d want %h@%0d", k, wr_data[base+k], wr_addr[base+k], exp_w[k], k);
         end
      end
      total++;
      if ({done, err, busy, core_hold} !== 4'b1000 || words_loaded !== 11'd3 || im_addr !== 10'd3 || im_data !== 16'h00FF) begin
         bad++;
         $display("FAIL nominal_end: d/e/b/h=%b words=%0d addr=%0d data=%h want 1000/3/3/00ff",
                  {done, err, busy, core_hold}, words_loaded, im_addr, im_data);
      end
   endtask

   task automatic test_done_idle;
      int base = nwr;
      int rdy_seen = 0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = 8'h77;
         @(negedge clk);
         if (in_ready) rdy_seen++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      total++;
      if (rdy_seen !== 0 || done !== 1'b1 || nwr - base !== 0) begin
         bad++;
         $display("FAIL done_idle: rdy_cycles=%0d done=%b writes=%0d want 0/1/0", rdy_seen, done, nwr - base);
      end
   endtask

   task automatic test_empty;
      int base = nwr;
      frm[0] = 8'h00; frm[1] = 8'h00; frm[2] = 8'h00;
`ifdef LOADER_CSUM_EN
      frm_len = 3;
`else
      frm_len = 2;
`endif
      pulse_start;
      total++;
      if (core_hold !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL restart_hold: core_hold=%b done=%b want 1/0", core_hold, done);
      end
      send_range(0, frm_len, 1'b0);
      wait_cycles(2);
      total++;
      if (nwr - base !== 0 || done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 11'd0) begin
         bad++;
         $display("FAIL empty: writes=%0d done=%b hold=%b words=%0d want 0/1/0/0", nwr - base, done, core_hold, words_loaded);
      end
   endtask

   task automatic test_oversize;
      int base = nwr;
      frm[0] = 8'h04; frm[1] = 8'h01;
      pulse_start;
      send_range(0, 2, 1'b0);
      total++;
      if ({err, done, core_hold, in_ready, busy} !== 5'b10100 || nwr - base !== 0) begin
         bad++;
         $display("FAIL oversize: e/d/h/r/b=%b writes=%0d want 10100/0", {err, done, core_hold, in_ready, busy}, nwr - base);
      end
      build_nominal;
      pulse_start;
      send_range(0, frm_len, 1'b0);
      wait_cycles(2);
      total++;
      if (done !== 1'b1 || err !== 1'b0 || nwr - base !== 3 || wr_data[base+2] !== 16'h00FF) begin
         bad++;
         $display("FAIL after_oversize: done=%b err=%b writes=%0d want 1/0/3", done, err, nwr - base);
      end
   endtask

`ifdef LOADER_CSUM_EN
   task automatic test_bad_csum;
      int base = nwr;
      build_nominal;
      frm[8] = 8'h99;
      pulse_start;
      send_range(0, frm_len, 1'b0);
      wait_cycles(1);
      total++;
      if (nwr - base !== 3 || err !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin
         bad++;
         $display("FAIL bad_csum: writes=%0d err=%b done=%b hold=%b want 3/1/0/1", nwr - base, err, done, core_hold);
      end
   endtask
`endif

   task automatic test_stall;
      int base = nwr;
      int v0 = viol;
      build_nominal;
      pulse_start;
      send_range(0, frm_len, 1'b1);
      wait_cycles(3);
      total++;
      if (nwr - base !== 3 || viol - v0 !== 0 || done !== 1'b1) begin
         bad++;
         $display("FAIL stall: writes=%0d rdy_in_write=%0d done=%b want 3/0/1", nwr - base, viol - v0, done);
      end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (wr_addr[base+k] !== 10'(k) || wr_data[base+k] !== exp_w[k]) begin
            bad++;
            $display("FAIL stall_word%0d: got %h@%0d want %h@%0d", k, wr_data[base+k], wr_addr[base+k], exp_w[k], k);
         end
      end
   endtask

   task automatic test_start_busy;
      int base = nwr;
      build_nominal;
      pulse_start;
      send_range(0, 5, 1'b0);
      pulse_start;
      total++;
      if (busy !== 1'b1 || words_loaded !== 11'd1) begin
         bad++;
         $display("FAIL start_busy_mid: busy=%b words=%0d want 1/1", busy, words_loaded);
      end
      send_range(5, frm_len, 1'b0);
      wait_cycles(3);
      total++;
      if (nwr - base !== 3 || wr_data[base+1] !== 16'hABCD || wr_data[base+2] !== 16'h00FF || done !== 1'b1) begin
         bad++;
         $display("FAIL start_busy: writes=%0d w1=%h w2=%h done=%b want 3/abcd/00ff/1",
                  nwr - base, wr_data[base+1], wr_data[base+2], done);
      end
   endtask

   task automatic test_reset_mid;
      int base = nwr;
      build_nominal;
      pulse_start;
      send_range(0, 4, 1'b0);
      total++;
      if (im_we !== 1'b1 || im_addr !== 10'd0 || im_data !== 16'h1234) begin
         bad++;
         $display("FAIL write_latency: im_we=%b addr=%0d data=%h want 1/0/1234", im_we, im_addr, im_data);
      end
      wait_cycles(1);
      in_valid = 1'b1;
      in_data  = frm[4];
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({core_hold, in_ready, im_we, busy, done, err} !== 6'b100000 ||
          im_addr !== 10'd0 || im_data !== 16'h0 || words_loaded !== 11'd0) begin
         bad++;
         $display("FAIL reset_mid: flags=%b addr=%0d data=%h words=%0d want 100000/0/0/0",
                  {core_hold, in_ready, im_we, busy, done, err}, im_addr, im_data, words_loaded);
      end
      wait_cycles(3);
      rst = 1'b0;
      wait_cycles(4);
      in_valid = 1'b0;
      total++;
      if (nwr - base !== 1 || busy !== 1'b0 || core_hold !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_after: writes=%0d busy=%b hold=%b want 1/0/1", nwr - base, busy, core_hold);
      end
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_done_idle;
      test_empty;
      test_oversize;
`ifdef LOADER_CSUM_EN
      test_bad_csum;
`endif
      test_stall;
      test_start_busy;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
